// File: rtl/spi_xfer_unit_pkg.sv
// spi_xfer_unit_pkg: shared widths and FSM state type for the serial front end
package spi_xfer_unit_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int LOAD_FRAME_W = ADDR_W + DATA_W;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_XFER, ST_DONE} state_t;
endpackage

// File: rtl/spi_xfer_unit_if.sv
// spi_xfer_unit_if: control-side and pin-side signals of the serial front end
interface spi_xfer_unit_if;
  import spi_xfer_unit_pkg::*;
  logic driver_io_in;
  logic read_in;
  logic send_in;
  logic [DATA_W-1:0] data_in;
  logic miso_in;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic ready_out;
  logic sclk_out;
  logic mosi_out;
  logic cs_out;
  modport master(
    output driver_io_in, read_in, send_in, data_in, miso_in,
    input addr_out, data_out, ready_out, sclk_out, mosi_out, cs_out
  );
  modport slave(
    input driver_io_in, read_in, send_in, data_in, miso_in,
    output addr_out, data_out, ready_out, sclk_out, mosi_out, cs_out
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: mode-0 sclk with rise/fall strobes that mark the edge on which sclk changes
module spi_sclk_gen #(
  parameter int HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = en && cnt == CW'(HALF - 1);
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + 1'b1;
      sclk <= tick ? ~sclk : sclk;
    end
  end
endmodule

// File: rtl/spi_xfer_unit.sv
// spi_xfer_unit: LOAD-mode frame deserialiser and EXEC-mode 8-bit SPI master
module spi_xfer_unit import spi_xfer_unit_pkg::*; #(
  parameter int SCLK_HALF = 1
) (
  input logic clk,
  input logic rst_n,
  spi_xfer_unit_if.slave bus
);
  state_t st;
  logic [LOAD_FRAME_W-1:0] sr, sr_nxt;
  logic [DATA_W-1:0] tx, rx;
  logic [2:0] bit_cnt;
  logic op, shift, start, sclk_en, rise, fall;
  assign shift = (st == ST_IDLE || st == ST_LOAD) && bus.driver_io_in && bus.read_in;
  assign start = st == ST_IDLE && !bus.driver_io_in && (bus.send_in || bus.read_in);
  // Dropping the enable on the abort edge lets sclk return low together with cs.
  assign sclk_en = st == ST_XFER && !bus.driver_io_in;
  assign sr_nxt = {sr[LOAD_FRAME_W-2:0], bus.miso_in};
  spi_sclk_gen #(.HALF(SCLK_HALF)) u_sclk (
    .clk(clk),
    .rst_n(rst_n),
    .en(sclk_en),
    .sclk(bus.sclk_out),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st           <= ST_IDLE;
      sr           <= '0;
      tx           <= '0;
      rx           <= '0;
      bit_cnt      <= '0;
      op           <= 1'b0;
      bus.addr_out <= '0;
      bus.data_out <= '0;
      bus.mosi_out <= 1'b0;
      bus.ready_out <= 1'b0;
      bus.cs_out   <= 1'b1;
    end else begin
      bus.ready_out <= 1'b0;
      if (shift) sr <= sr_nxt;
      if (shift) bus.data_out <= sr_nxt[DATA_W-1:0];
      bus.addr_out <= shift ? sr_nxt[LOAD_FRAME_W-1:DATA_W] : bus.driver_io_in ? bus.addr_out : '0;
      case (st)
        ST_IDLE: begin
          if (shift) st <= ST_LOAD;
          else if (start) begin
            st           <= ST_XFER;
            tx           <= bus.data_in;
            op           <= bus.read_in;
            bit_cnt      <= '0;
            bus.cs_out   <= 1'b0;
            bus.mosi_out <= bus.data_in[DATA_W-1];
          end
        end
        ST_LOAD: if (!shift) st <= ST_IDLE;
        ST_XFER: begin
          if (bus.driver_io_in) begin
            st           <= ST_IDLE;
            bus.cs_out   <= 1'b1;
            bus.mosi_out <= 1'b0;
          end else begin
            if (rise) rx <= {rx[DATA_W-2:0], bus.miso_in};
            if (fall && bit_cnt == 3'd7) begin
              st            <= ST_DONE;
              bus.cs_out    <= 1'b1;
              bus.mosi_out  <= 1'b0;
              bus.ready_out <= 1'b1;
              if (op) bus.data_out <= rx;
            end else if (fall) begin
              bit_cnt      <= bit_cnt + 3'd1;
              tx           <= tx << 1;
              bus.mosi_out <= tx[DATA_W-2];
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_unit.sv
// tb_spi_xfer_unit: directed plus randomized checks against a bit-level reference model
module tb_spi_xfer_unit;
  import spi_xfer_unit_pkg::*;
  localparam int H = 1;
  localparam int L = 1 + 16 * H;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [11:0] model_sr = '0;
  logic [7:0] exp_data = '0;
  always #5 clk = ~clk;
  spi_xfer_unit_if bus();
  spi_xfer_unit #(.SCLK_HALF(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [31:0] bits);
    bus.driver_io_in = 1'b1;
    bus.read_in = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      bus.miso_in = bits[i];
      model_sr = {model_sr[10:0], bits[i]};
      step();
      chk("load_idle_pins", {29'd0, bus.cs_out, bus.sclk_out, bus.mosi_out}, 32'b100);
    end
    exp_data = model_sr[7:0];
    bus.read_in = 1'b0;
    bus.miso_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("load_addr", bus.addr_out, model_sr[11:8]);
      chk("load_data", bus.data_out, exp_data);
    end
  endtask

  task automatic xfer(input bit rd, input logic [7:0] din, input logic [7:0] mb, input int abort_bit);
    logic [7:0] mosi_cap = '0;
    logic [7:0] data_at_rdy = '0;
    logic prev_sclk = 1'b0;
    int rises = 0, cs_low = 0, rdy_cnt = 0, rdy_cyc = -1;
    bit aborted = 0;
    bus.driver_io_in = 1'b0;
    bus.read_in = rd;
    bus.send_in = !rd;
    bus.data_in = din;
    bus.miso_in = mb[7];
    for (int c = 1; c <= L + 3; c++) begin
      step();
      if (c == 1) begin
        bus.read_in = 1'b0;
        bus.send_in = 1'b0;
        bus.data_in = 8'($urandom);
      end
      if (aborted) begin
        chk("abort_cs", bus.cs_out, 1);
        chk("abort_sclk", bus.sclk_out, 0);
        chk("abort_ready", bus.ready_out, 0);
        break;
      end
      if (bus.cs_out === 1'b0) cs_low++;
      if (bus.ready_out === 1'b1) begin
        rdy_cnt++;
        rdy_cyc = c;
        data_at_rdy = bus.data_out;
      end
      if (bus.sclk_out === 1'b1 && !prev_sclk) begin
        mosi_cap = {mosi_cap[6:0], bus.mosi_out};
        rises++;
      end
      if (bus.sclk_out === 1'b0 && rises < 8) bus.miso_in = mb[7-rises];
      prev_sclk = bus.sclk_out;
      if (abort_bit >= 0 && !aborted && rises == abort_bit && bus.sclk_out === 1'b1) begin
        bus.driver_io_in = 1'b1;
        aborted = 1;
      end
    end
    if (rd) exp_data = (abort_bit >= 0) ? exp_data : mb;
    if (abort_bit >= 0) begin
      chk("abort_reached", {31'd0, aborted}, 1);
      for (int c = 0; c < L; c++) begin
        step();
        if (bus.ready_out === 1'b1) rdy_cnt++;
      end
      chk("abort_no_ready", rdy_cnt, 0);
      chk("abort_data_keep", bus.data_out, exp_data);
      bus.driver_io_in = 1'b0;
    end else begin
      chk("xfer_cs_low", cs_low, 16 * H);
      chk("xfer_ready_cnt", rdy_cnt, 1);
      chk("xfer_ready_cyc", rdy_cyc, L);
      chk("xfer_rises", rises, 8);
      chk("xfer_mosi", mosi_cap, din);
      chk("xfer_data_at_ready", data_at_rdy, exp_data);
      chk("xfer_data_out", bus.data_out, exp_data);
      chk("xfer_addr_zero", bus.addr_out, 0);
    end
    step();
  endtask

  initial begin
    int r1, r2, rc;
    bus.driver_io_in = 1'b0;
    bus.read_in = 1'b0;
    bus.send_in = 1'b1;
    bus.data_in = 8'hFF;
    bus.miso_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_pins", {28'd0, bus.cs_out, bus.sclk_out, bus.ready_out, bus.mosi_out}, 32'b1000);
      chk("rst_data", {bus.addr_out, bus.data_out}, 0);
    end
    bus.send_in = 1'b0;
    bus.miso_in = 1'b0;
    rst_n = 1'b1;
    step();
    load(12, 32'hA5C);
    chk("load_addr_a", bus.addr_out, 4'hA);
    chk("load_data_5c", bus.data_out, 8'h5C);
    bus.driver_io_in = 1'b0;
    step();
    chk("exec_addr_zero", bus.addr_out, 0);
    xfer(0, 8'hB3, 8'($urandom), -1);
    xfer(1, 8'($urandom), 8'h6E, -1);
    r1 = -1;
    r2 = -1;
    rc = 0;
    bus.send_in = 1'b1;
    bus.data_in = 8'h5A;
    for (int c = 1; c <= 2 * L + 6; c++) begin
      step();
      if (bus.ready_out === 1'b1) begin
        rc++;
        if (rc == 1) r1 = c;
        if (rc == 2) r2 = c;
        if (rc == 2) bus.send_in = 1'b0;
      end
      if (c == L + 1) chk("b2b_cs_gap", bus.cs_out, 1);
      if (c == L + 2) chk("b2b_cs_restart", bus.cs_out, 0);
    end
    chk("b2b_ready_cnt", rc, 2);
    chk("b2b_first_ready", r1, L);
    chk("b2b_second_ready", r2, 2 * L + 1);
    chk("b2b_cs_idle", bus.cs_out, 1);
    xfer(1, 8'($urandom), 8'($urandom), 4);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(5, 20));
      load(n, $urandom);
      bus.driver_io_in = 1'b0;
      step();
      xfer(1'($urandom), 8'($urandom), 8'($urandom), -1);
    end
    bus.send_in = 1'b1;
    bus.data_in = 8'hFF;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    step();
    chk("midrst_pins", {28'd0, bus.cs_out, bus.sclk_out, bus.ready_out, bus.mosi_out}, 32'b1000);
    chk("midrst_data", {bus.addr_out, bus.data_out}, 0);
    rst_n = 1'b1;
    bus.send_in = 1'b0;
    model_sr = '0;
    exp_data = '0;
    step();
    load(7, 32'h55);
    bus.driver_io_in = 1'b0;
    step();
    xfer(1, 8'h81, 8'hC3, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
